// File: rtl/serial_parallel_mult_if.sv
// Operand/product bundle for the serial-parallel multiplier.
// master drives x (serial) and a (parallel); slave returns y (serial).
interface serial_parallel_mult_if #(
   parameter int SIZE = 32
);
   logic            x;
   logic [SIZE-1:0] a;
   logic            y;

   modport master (
      output x,
      output a,
      input  y
   );

   modport slave (
      input  x,
      input  a,
      output y
   );
endinterface

// File: rtl/serial_parallel_mult.sv
// Carry-save serial-parallel unsigned multiplier; x streams in LSB first,
// 2*SIZE-bit product streams out on y LSB first. Ports: clk, rst (async low), bus.
module serial_parallel_mult #(
   parameter int SIZE = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   serial_parallel_mult_if.slave      bus
);

   logic [SIZE-1:0] s;
   logic [SIZE-1:0] c;
   logic [SIZE-1:0] pp;
   logic [SIZE-1:0] s_in;
   logic [SIZE-1:0] sum;
   logic [SIZE-1:0] cry;

   // Slice i adds the sum of slice i+1 (one weight lower after the
   // implicit shift); the top slice sees 0.
   assign pp   = bus.a & {SIZE{bus.x}};
   assign s_in = {1'b0, s[SIZE-1:1]};
   assign sum  = pp ^ s_in ^ c;
   assign cry  = (pp & s_in) | (pp & c) | (s_in & c);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s <= '0;
         c <= '0;
      end else begin
         s <= sum;
         c <= cry;
      end
   end

   // LSB slice sum flop is the registered product bit.
   assign bus.y = s[0];

endmodule

// File: tb/tb_serial_parallel_mult.sv
// Self-checking bench for serial_parallel_mult (SIZE=32).
// Directed + random operands checked against a*x computed arithmetically.
module tb_serial_parallel_mult;

   localparam int SIZE = 32;

   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;

   serial_parallel_mult_if #(.SIZE(SIZE)) bus ();

   serial_parallel_mult #(.SIZE(SIZE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Pulse reset, load a, stream x over 2*SIZE edges, collect y LSB first.
   task automatic run_op(input  logic [SIZE-1:0] av,
                         input  logic [SIZE-1:0] xv,
                         input  string tag,
                         output logic [63:0] col);
      @(negedge clk);
      rst   = 1'b0;
      bus.x = 1'b0;
      bus.a = av;
      @(negedge clk);
      chk({tag, "_rst_y"}, {63'd0, bus.y}, 64'd0);
      rst = 1'b1;
      col = '0;
      for (int k = 0; k < 2 * SIZE; k++) begin
         bus.x = (k < SIZE) ? xv[k] : 1'b0;
         @(posedge clk);
         #1;
         col[k] = bus.y;
         @(negedge clk);
      end
      bus.x = 1'b0;
   endtask

   task automatic flush_chk(input string tag);
      logic seen;
      seen = 1'b0;
      bus.x = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         seen = seen | bus.y;
      end
      chk(tag, {63'd0, seen}, 64'd0);
   endtask

   function automatic logic [63:0] model(input logic [SIZE-1:0] av,
                                         input logic [SIZE-1:0] xv);
      logic [63:0] wa;
      logic [63:0] wx;
      wa = 64'(av);
      wx = 64'(xv);
      return wa * wx;
   endfunction

   initial begin
      logic [63:0]     col;
      logic [SIZE-1:0] ra;
      logic [SIZE-1:0] rx;
      n_pass  = 0;
      n_total = 0;
      rst     = 1'b0;
      bus.x   = 1'b0;
      bus.a   = '0;
      #12;
      chk("por_y", {63'd0, bus.y}, 64'd0);

      run_op(32'd3, 32'd5, "small", col);
      chk("small", col, model(32'd3, 32'd5));
      chk("small_lo6", {58'd0, col[5:0]}, 64'h0F);
      flush_chk("small_flush");

      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max", col);
      chk("max", col, 64'hFFFF_FFFE_0000_0001);
      flush_chk("max_flush");

      run_op(32'h1234_5678, 32'd0, "zero_x", col);
      chk("zero_x", col, 64'd0);
      run_op(32'd0, 32'hFFFF_FFFF, "zero_a", col);
      chk("zero_a", col, 64'd0);

      // Abort mid-operation: async reset must clear y without a clock.
      @(negedge clk);
      rst   = 1'b0;
      bus.a = 32'hDEAD_BEEF;
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k <= 20; k++) begin
         bus.x = rx_bit(32'h0BAD_F00D, k);
         @(posedge clk);
         #1;
         if (k < 20) @(negedge clk);
      end
      #1;
      rst = 1'b0;
      #1;
      chk("midop_async_y", {63'd0, bus.y}, 64'd0);
      run_op(32'd7, 32'd6, "after_abort", col);
      chk("after_abort", col, 64'h2A);

      for (int i = 0; i < 20; i++) begin
         ra = $urandom;
         rx = $urandom;
         run_op(ra, rx, "rand", col);
         chk($sformatf("rand%0d", i), col, model(ra, rx));
      end
      flush_chk("rand_flush");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   function automatic logic rx_bit(input logic [SIZE-1:0] v, input int k);
      return v[k];
   endfunction

endmodule
